conv5x5_gauss: RTL and testbench

Fixed-coefficient 5x5 Gaussian blur stage that sits directly downstream of the 5-line pixel window generator. Each valid cycle it accepts one 5-pixel vertical column and shifts it into a 5-column register window. It computes the 1-4-6-4-1 separable weighted sum over that window and emits one filtered pixel per accepted column. Valid and sync flags are delayed to match the arithmetic pipeline, so the next stage sees aligned control.

---
 rtl/conv5x5_gauss_pkg.sv | 20 ++
 rtl/conv5x5_gauss_row_sum5.sv | 19 +
 rtl/conv5x5_gauss.sv | 113 +++++++++++
 tb/tb_conv5x5_gauss.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv5x5_gauss_pkg.sv
// Shared constants and control-flag bundle for the 5x5 Gaussian blur stage.
package conv_pkg;

    localparam int unsigned PIX_W_DEF    = 8;
    localparam int unsigned LATENCY      = 3;
    localparam int unsigned K0           = 1;
    localparam int unsigned K1           = 4;
    localparam int unsigned K2           = 6;
    localparam int unsigned K3           = 4;
    localparam int unsigned K4           = 1;
    localparam int unsigned KERNEL_SHIFT = 8;

    typedef struct packed {
        logic valid;
        logic border;
        logic h_sync;
        logic v_sync;
    } ctrl_t;

endpackage

// File: rtl/conv5x5_gauss_row_sum5.sv
// 1-4-6-4-1 weighted sum of five IN_W-bit operands using shifts and adds only.
module row_sum5 #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = IN_W + 4
) (
    input  logic [5*IN_W-1:0] x_i,
    output logic [OUT_W-1:0]  sum_o
);

    logic [OUT_W-1:0] e [5];

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            e[i] = OUT_W'(x_i[i*IN_W +: IN_W]);
        end
        sum_o = e[0] + (e[1] << 2) + (e[2] << 2) + (e[2] << 1) + (e[3] << 2) + e[4];
    end

endmodule

// File: rtl/conv5x5_gauss.sv
// 5x5 Gaussian blur, 3-clock latency, left-border passthrough of the center pixel.
// Define CONV5X5_ROUND_EN for round-half-up output; otherwise the output truncates.
module conv5x5_gauss
    import conv_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5*PIX_W-1:0] column_i,
    input  logic               valid_i,
    input  logic               h_sync_i,
    input  logic               v_sync_i,
    output logic [PIX_W-1:0]   pixel_o,
    output logic               valid_o,
    output logic               border_o,
    output logic               h_sync_o,
    output logic               v_sync_o
);

    localparam int unsigned H_W   = PIX_W + 4;
    localparam int unsigned SUM_W = PIX_W + 8;

    logic [PIX_W-1:0] win_q [5][5];
    logic [PIX_W-1:0] win_d [5][5];
    logic [2:0]       col_cnt_q, col_cnt_d;
    ctrl_t            ctrl_q [LATENCY];
    ctrl_t            ctrl_d;

    logic [5*PIX_W-1:0] row_vec [5];
    logic [H_W-1:0]     h_sum [5];
    logic [H_W-1:0]     h_q [5];
    logic [PIX_W-1:0]   center_q;
    logic [5*H_W-1:0]   v_vec;
    logic [SUM_W-1:0]   v_sum, v_rnd;
    logic [PIX_W-1:0]   pixel_q, pixel_d;

    // Line-start clear is applied before the shift so a coincident column lands in slot 0.
    always_comb begin
        win_d     = win_q;
        col_cnt_d = col_cnt_q;
        if (h_sync_i) begin
            win_d     = '{default: '0};
            col_cnt_d = '0;
        end
        if (valid_i) begin
            for (int unsigned r = 0; r < 5; r++) begin
                for (int unsigned c = 4; c >= 1; c--) begin
                    win_d[r][c] = win_d[r][c-1];
                end
                win_d[r][0] = column_i[r*PIX_W +: PIX_W];
            end
            if (col_cnt_d != 3'd5) begin
                col_cnt_d = col_cnt_d + 3'd1;
            end
        end
        ctrl_d.valid  = valid_i;
        ctrl_d.border = valid_i & (col_cnt_d != 3'd5);
        ctrl_d.h_sync = h_sync_i;
        ctrl_d.v_sync = v_sync_i;
    end

    for (genvar r = 0; r < 5; r++) begin : g_hsum
        assign row_vec[r] = {win_q[r][4], win_q[r][3], win_q[r][2], win_q[r][1], win_q[r][0]};
        row_sum5 #(.IN_W(PIX_W)) u_hsum (
            .x_i   (row_vec[r]),
            .sum_o (h_sum[r])
        );
    end

    assign v_vec = {h_q[4], h_q[3], h_q[2], h_q[1], h_q[0]};

    row_sum5 #(.IN_W(H_W)) u_vsum (
        .x_i   (v_vec),
        .sum_o (v_sum)
    );

`ifdef CONV5X5_ROUND_EN
    assign v_rnd = v_sum + SUM_W'(1 << (KERNEL_SHIFT - 1));
`else
    assign v_rnd = v_sum;
`endif

    assign pixel_d = ctrl_q[LATENCY-2].border ? center_q : PIX_W'(v_rnd >> KERNEL_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q     <= '{default: '0};
            col_cnt_q <= '0;
            ctrl_q    <= '{default: '0};
            h_q       <= '{default: '0};
            center_q  <= '0;
            pixel_q   <= '0;
        end else begin
            win_q     <= win_d;
            col_cnt_q <= col_cnt_d;
            ctrl_q[0] <= ctrl_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                ctrl_q[i] <= ctrl_q[i-1];
            end
            h_q       <= h_sum;
            center_q  <= win_q[2][2];
            pixel_q   <= pixel_d;
        end
    end

    assign pixel_o  = pixel_q;
    assign valid_o  = ctrl_q[LATENCY-1].valid;
    assign border_o = ctrl_q[LATENCY-1].border;
    assign h_sync_o = ctrl_q[LATENCY-1].h_sync;
    assign v_sync_o = ctrl_q[LATENCY-1].v_sync;

endmodule

// File: tb/tb_conv5x5_gauss.sv
// Directed self-checking bench for conv5x5_gauss (honours CONV5X5_ROUND_EN if defined).
module tb_conv5x5_gauss;

    localparam int unsigned PIX_W = 8;
`ifdef CONV5X5_ROUND_EN
    localparam logic [7:0] IMP_EXP = 8'd36;
`else
    localparam logic [7:0] IMP_EXP = 8'd35;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [5*PIX_W-1:0] column_i = '0;
    logic               valid_i = 1'b0;
    logic               h_sync_i = 1'b0;
    logic               v_sync_i = 1'b0;
    logic [PIX_W-1:0]   pixel_o;
    logic               valid_o, border_o, h_sync_o, v_sync_o;

    int cmp_cnt = 0;
    int err_cnt = 0;

    conv5x5_gauss #(.PIX_W(PIX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .column_i (column_i),
        .valid_i  (valid_i),
        .h_sync_i (h_sync_i),
        .v_sync_i (v_sync_i),
        .pixel_o  (pixel_o),
        .valid_o  (valid_o),
        .border_o (border_o),
        .h_sync_o (h_sync_o),
        .v_sync_o (v_sync_o)
    );

    always #5 clk = ~clk;

    function automatic logic [5*PIX_W-1:0] col_all(input logic [7:0] v);
        return {5{v}};
    endfunction

    task automatic idle();
        valid_i  = 1'b0;
        h_sync_i = 1'b0;
        v_sync_i = 1'b0;
        column_i = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rst = 1'b0; valid_i = 1'b1; column_i = col_all(8'd77);
        end
        @(posedge clk); #1;
        rst = 1'b1; idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp_cnt++;
            if ({pixel_o, valid_o, border_o, h_sync_o, v_sync_o} !== 12'd0) begin
                err_cnt++;
                $display("FAIL reset_outs k=%0d got pix=%0d v=%0b b=%0b h=%0b vs=%0b exp all 0",
                         k, pixel_o, valid_o, border_o, h_sync_o, v_sync_o);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            if (k >= 1 && k <= 2) begin
                cmp_cnt++;
                if (valid_o !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL reset_latency_early k=%0d got %0b exp 0", k, valid_o);
                end
            end
            if (k == 3) begin
                cmp_cnt++;
                if ({valid_o, border_o, pixel_o} !== {1'b1, 1'b1, 8'd0}) begin
                    err_cnt++;
                    $display("FAIL reset_first_valid got v=%0b b=%0b pix=%0d exp v=1 b=1 pix=0",
                             valid_o, border_o, pixel_o);
                end
            end
            idle();
            if (k == 0) begin
                valid_i = 1'b1; column_i = col_all(8'd9);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flat_field();
        logic [7:0] exp_pix;
        logic       exp_v, exp_b;
        for (int k = 0; k <= 14; k++) begin
            exp_v = (k >= 4 && k <= 13);
            cmp_cnt++;
            if (valid_o !== exp_v) begin
                err_cnt++;
                $display("FAIL flat_valid k=%0d got %0b exp %0b", k, valid_o, exp_v);
            end
            if (exp_v) begin
                exp_pix = (k - 4 < 2) ? 8'd0 : 8'd100;
                exp_b   = (k - 4 < 4);
                cmp_cnt++;
                if ({border_o, pixel_o} !== {exp_b, exp_pix}) begin
                    err_cnt++;
                    $display("FAIL flat_pix k=%0d got b=%0b pix=%0d exp b=%0b pix=%0d",
                             k, border_o, pixel_o, exp_b, exp_pix);
                end
            end
            idle();
            if (k == 0) h_sync_i = 1'b1;
            if (k >= 1 && k <= 10) begin
                valid_i = 1'b1; column_i = col_all(8'd100);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_impulse();
        for (int k = 0; k <= 8; k++) begin
            if (k >= 4 && k <= 7) begin
                cmp_cnt++;
                if ({valid_o, border_o} !== 2'b11) begin
                    err_cnt++;
                    $display("FAIL impulse_border k=%0d got v=%0b b=%0b exp v=1 b=1", k, valid_o, border_o);
                end
            end
            if (k == 8) begin
                cmp_cnt++;
                if ({valid_o, border_o, pixel_o} !== {1'b1, 1'b0, IMP_EXP}) begin
                    err_cnt++;
                    $display("FAIL impulse_pix got v=%0b b=%0b pix=%0d exp v=1 b=0 pix=%0d",
                             valid_o, border_o, pixel_o, IMP_EXP);
                end
            end
            idle();
            if (k == 0) h_sync_i = 1'b1;
            if (k >= 1 && k <= 5) begin
                valid_i = 1'b1;
                if (k == 3) column_i[2*PIX_W +: PIX_W] = 8'd255;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k <= 7; k++) begin
            if (k == 3) begin
                cmp_cnt++;
                if ({valid_o, border_o} !== 2'b10) begin
                    err_cnt++;
                    $display("FAIL sat_full k=%0d got v=%0b b=%0b exp v=1 b=0", k, valid_o, border_o);
                end
            end
            if (k == 7) begin
                cmp_cnt++;
                if ({valid_o, border_o, pixel_o} !== {1'b1, 1'b0, 8'd255}) begin
                    err_cnt++;
                    $display("FAIL sat_pix got v=%0b b=%0b pix=%0d exp v=1 b=0 pix=255",
                             valid_o, border_o, pixel_o);
                end
            end
            idle();
            if (k <= 4) begin
                valid_i = 1'b1; column_i = col_all(8'd255);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_valid_gaps();
        logic       exp_v, exp_s;
        logic [7:0] exp_pix;
        for (int k = 0; k <= 7; k++) begin
            exp_s = (k == 3);
            cmp_cnt++;
            if ({h_sync_o, v_sync_o} !== {exp_s, exp_s}) begin
                err_cnt++;
                $display("FAIL gap_sync k=%0d got h=%0b v=%0b exp %0b", k, h_sync_o, v_sync_o, exp_s);
            end
            if (k >= 3) begin
                exp_v = (k == 3 || k == 6 || k == 7);
                cmp_cnt++;
                if (valid_o !== exp_v) begin
                    err_cnt++;
                    $display("FAIL gap_valid k=%0d got %0b exp %0b", k, valid_o, exp_v);
                end
                if (exp_v) begin
                    exp_pix = (k == 7) ? 8'd10 : 8'd0;
                    cmp_cnt++;
                    if ({border_o, pixel_o} !== {1'b1, exp_pix}) begin
                        err_cnt++;
                        $display("FAIL gap_pix k=%0d got b=%0b pix=%0d exp b=1 pix=%0d",
                                 k, border_o, pixel_o, exp_pix);
                    end
                end
            end
            idle();
            case (k)
                0: begin valid_i = 1'b1; h_sync_i = 1'b1; v_sync_i = 1'b1; column_i = col_all(8'd10); end
                3: begin valid_i = 1'b1; column_i = col_all(8'd20); end
                4: begin valid_i = 1'b1; column_i = col_all(8'd30); end
                default: ;
            endcase
            @(posedge clk); #1;
        end
    endtask

    task automatic test_midline_hsync();
        logic [7:0] exp_pix;
        logic       exp_b;
        for (int k = 0; k <= 9; k++) begin
            if (k == 4) begin
                cmp_cnt++;
                if ({valid_o, border_o} !== 2'b10) begin
                    err_cnt++;
                    $display("FAIL mid_prefull got v=%0b b=%0b exp v=1 b=0", valid_o, border_o);
                end
            end
            if (k >= 5) begin
                case (k)
                    7:       exp_pix = 8'd50;
                    8:       exp_pix = 8'd60;
                    9:       exp_pix = 8'd70;
                    default: exp_pix = 8'd0;
                endcase
                exp_b = (k != 9);
                cmp_cnt++;
                if ({valid_o, border_o, pixel_o} !== {1'b1, exp_b, exp_pix}) begin
                    err_cnt++;
                    $display("FAIL mid_pix k=%0d got v=%0b b=%0b pix=%0d exp v=1 b=%0b pix=%0d",
                             k, valid_o, border_o, pixel_o, exp_b, exp_pix);
                end
            end
            idle();
            if (k <= 1) begin
                valid_i = 1'b1; column_i = col_all(8'h11);
            end else if (k <= 6) begin
                valid_i  = 1'b1;
                h_sync_i = (k == 2);
                column_i = col_all(8'(30 + 10 * k));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        test_flat_field();
        test_impulse();
        test_saturation();
        test_valid_gaps();
        test_midline_hsync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
